// File: rtl/stopwatch_bcd_counter_if.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd_counter_if
//
// Control and display bundle between the stopwatch control FSM / testbench
// (master side) and the BCD stopwatch counter (slave side).
//
// Signals:
//   clear         master -> slave  one-cycle synchronous clear pulse
//   count_enable  master -> slave  level, 1 = live counter runs
//   lap_enable    master -> slave  level, 1 = display frozen at lap snapshot
//   disp_sec_t    slave -> master  displayed seconds tens digit (BCD 0-5)
//   disp_sec_o    slave -> master  displayed seconds ones digit (BCD 0-9)
//   disp_cs_t     slave -> master  displayed hundredths tens digit (BCD 0-9)
//   disp_cs_o     slave -> master  displayed hundredths ones digit (BCD 0-9)
//   wrap          slave -> master  one-cycle pulse on live rollover 59.99->00.00
// -----------------------------------------------------------------------------
interface stopwatch_bcd_counter_if;
    logic       clear;
    logic       count_enable;
    logic       lap_enable;
    logic [3:0] disp_sec_t;
    logic [3:0] disp_sec_o;
    logic [3:0] disp_cs_t;
    logic [3:0] disp_cs_o;
    logic       wrap;

    modport master (
        output clear,
        output count_enable,
        output lap_enable,
        input  disp_sec_t,
        input  disp_sec_o,
        input  disp_cs_t,
        input  disp_cs_o,
        input  wrap
    );

    modport slave (
        input  clear,
        input  count_enable,
        input  lap_enable,
        output disp_sec_t,
        output disp_sec_o,
        output disp_cs_t,
        output disp_cs_o,
        output wrap
    );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd_counter
//
// Four-digit BCD stopwatch (SS.cc, 00.00 - 59.99). A prescaler divides clk_100
// by TICK_DIV while count_enable is high; each prescaler terminal count advances
// the live count by one hundredth. The display registers follow the live count
// with zero lag unless lap_enable is high, in which case they hold a snapshot
// while the live count keeps running.
//
// Parameters:
//   TICK_DIV   clk_100 cycles per hundredth-second step (1..255)
//
// Ports:
//   clk_100    system clock, rising edge
//   rst        synchronous active-high reset
//   bus        stopwatch_bcd_counter_if.slave (clear, count_enable, lap_enable
//              in; disp_sec_t, disp_sec_o, disp_cs_t, disp_cs_o, wrap out)
//
// Build option:
//   STOPWATCH_SATURATE_EN  when defined the live count stops at 59.99 instead
//                          of wrapping and wrap is never asserted.
// -----------------------------------------------------------------------------
module stopwatch_bcd_counter #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                          clk_100,
    input  logic                          rst,
    stopwatch_bcd_counter_if.slave        bus
);

    localparam int         NUM_DIGITS = 4;
    localparam logic [7:0] TICK_LAST  = 8'(TICK_DIV - 1);

    // Digit index: 0 = cs_o, 1 = cs_t, 2 = sec_o, 3 = sec_t
    logic [7:0]            prescale_reg;
    logic [7:0]            prescale_next;
    logic                  tick_step;
    logic                  step_eff;
    logic [3:0]            live_reg  [NUM_DIGITS];
    logic [3:0]            live_next [NUM_DIGITS];
    logic [3:0]            disp_reg  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] at_max;
    logic                  all_max;
    logic                  wrap_reg;
    logic                  wrap_next;
    logic                  zero_all;

    assign zero_all = rst | bus.clear;

    // -------------------------------------------------------------------------
    // Prescaler: only advances on enabled edges and keeps its partial count
    // across a pause so resume continues the interrupted hundredth.
    // -------------------------------------------------------------------------
    always_comb begin
        prescale_next = prescale_reg;
        tick_step     = 1'b0;
        if (bus.count_enable) begin
            if (prescale_reg == TICK_LAST) begin
                prescale_next = 8'd0;
                tick_step     = 1'b1;
            end else begin
                prescale_next = prescale_reg + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-digit increment. Each digit's carry-in is the step qualified by all
    // lower digits sitting at their maximum; computing it directly from at_max
    // (instead of chaining carry bits) keeps the logic free of combinational
    // dependencies between bits of one vector. A digit at or above its maximum
    // is treated as the maximum, so an out-of-range value wraps to 0.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            localparam logic [3:0] DIGIT_MAX = (gi == NUM_DIGITS - 1) ? 4'd5 : 4'd9;
            logic carry_in;

            assign at_max[gi] = (live_reg[gi] >= DIGIT_MAX);

            if (gi == 0) begin : g_lsd
                assign carry_in = step_eff;
            end else begin : g_upper
                assign carry_in = step_eff & (&at_max[gi-1:0]);
            end

            assign live_next[gi] = !carry_in ? live_reg[gi]
                                 : (at_max[gi] ? 4'd0 : live_reg[gi] + 4'd1);
        end
    endgenerate

    assign all_max = &at_max;

`ifdef STOPWATCH_SATURATE_EN
    // Parked at 59.99: steps are swallowed, prescaler keeps running.
    assign step_eff  = tick_step & ~all_max;
    assign wrap_next = 1'b0;
`else
    assign step_eff  = tick_step;
    assign wrap_next = tick_step & all_max;
`endif

    // -------------------------------------------------------------------------
    // State registers. rst and clear share the same zeroing path; clear also
    // overrides a frozen lap display.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_100) begin
        if (zero_all) begin
            prescale_reg <= 8'd0;
            wrap_reg     <= 1'b0;
        end else begin
            prescale_reg <= prescale_next;
            wrap_reg     <= wrap_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_reg
            always_ff @(posedge clk_100) begin
                if (zero_all) begin
                    live_reg[gi] <= 4'd0;
                    disp_reg[gi] <= 4'd0;
                end else begin
                    live_reg[gi] <= live_next[gi];
                    // Display loads the post-edge live value, so it shows the
                    // live count with no lag; during lap it simply holds.
                    if (!bus.lap_enable) begin
                        disp_reg[gi] <= live_next[gi];
                    end
                end
            end
        end
    endgenerate

    assign bus.disp_cs_o  = disp_reg[0];
    assign bus.disp_cs_t  = disp_reg[1];
    assign bus.disp_sec_o = disp_reg[2];
    assign bus.disp_sec_t = disp_reg[3];
    assign bus.wrap       = wrap_reg;

endmodule
